// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module : calc_pkg
// Brief  : Shared calculator types and default widths for the BCD result path.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DEF_IN_W = 16;
  localparam int DEF_NDIG = 5;
  localparam int BCD_W    = 4;

endpackage

`default_nettype wire

// File: rtl/result_bcd_converter_if.sv
//------------------------------------------------------------------------------
// Module : result_bcd_converter_if
// Brief  : ALU-side request and display-side result bundle for the converter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface result_bcd_converter_if
  import calc_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int NDIG = DEF_NDIG
);

  logic                  start;
  logic [IN_W-1:0]       result;
  logic                  neg;
  logic                  busy;
  logic                  done;
  logic [BCD_W*NDIG-1:0] digits;
  logic                  sign;
  logic [2:0]            num_digits;

  modport master (
    output start, result, neg,
    input  busy, done, digits, sign, num_digits
  );

  modport slave (
    input  start, result, neg,
    output busy, done, digits, sign, num_digits
  );

endinterface

`default_nettype wire

// File: rtl/bcd_add3.sv
//------------------------------------------------------------------------------
// Module : bcd_add3
// Brief  : Double-dabble digit correction: adds 3 when the digit is 5 or more.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_add3 (
  input  wire logic [3:0] i_val,
  output      logic [3:0] o_val
);

  assign o_val = (i_val >= 4'd5) ? (i_val + 4'd3) : i_val;

endmodule

`default_nettype wire

// File: rtl/result_bcd_converter.sv
//------------------------------------------------------------------------------
// Module : result_bcd_converter
// Brief  : Serial binary-to-BCD converter (one bit per clock) for the display.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int NDIG = DEF_NDIG
) (
  input wire logic              clk,
  input wire logic              rst,
  result_bcd_converter_if.slave bus
);

  localparam int CNT_W   = $clog2(IN_W + 1);
  localparam int BCD_TOT = BCD_W * NDIG;
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(IN_W - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_load;
  logic                 w_last;

  logic [IN_W-1:0]      r_bin;
  logic [BCD_TOT-1:0]   r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sign_cap;

  logic [BCD_TOT-1:0]   w_corr;
  logic [BCD_TOT-1:0]   w_bcd_next;
  logic [2:0]           w_num_digits;

  logic [BCD_TOT-1:0]   r_digits;
  logic                 r_sign;
  logic [2:0]           r_num_digits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == c_last_bit) begin
          w_last       = 1'b1;
          w_next_state = FINISH;
        end
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_add3
    bcd_add3 u_add3 (
      .i_val (r_bcd [i*BCD_W +: BCD_W]),
      .o_val (w_corr[i*BCD_W +: BCD_W])
    );
  end

  // Correction and shift share one cycle: the corrected digits shift left with the next binary MSB.
  assign w_bcd_next = {w_corr[BCD_TOT-2:0], r_bin[IN_W-1]};

  always_comb begin
    w_num_digits = 3'd1;
    for (int i = 1; i < NDIG; i++) begin
      if (w_bcd_next[i*BCD_W +: BCD_W] != '0) begin
        w_num_digits = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_sign_cap   <= 1'b0;
      r_digits     <= '0;
      r_sign       <= 1'b0;
      r_num_digits <= 3'd1;
    end else begin
      if (w_load) begin
        r_bin      <= bus.result;
        r_bcd      <= '0;
        r_cnt      <= '0;
        r_sign_cap <= bus.neg && (bus.result != '0);
      end else if (r_state == SHIFT) begin
        r_bin <= {r_bin[IN_W-2:0], 1'b0};
        r_bcd <= w_bcd_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_digits     <= w_bcd_next;
        r_sign       <= r_sign_cap;
        r_num_digits <= w_num_digits;
      end
    end
  end

  assign bus.busy       = (r_state == SHIFT);
  assign bus.done       = (r_state == FINISH);
  assign bus.digits     = r_digits;
  assign bus.sign       = r_sign;
  assign bus.num_digits = r_num_digits;

endmodule

`default_nettype wire

// File: tb/tb_result_bcd_converter.sv
//------------------------------------------------------------------------------
// Module : tb_result_bcd_converter
// Brief  : Scoreboard bench for result_bcd_converter against a decimal model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_result_bcd_converter;

  localparam int IN_W = 16;
  localparam int NDIG = 5;

  typedef struct packed {
    logic [19:0] digits;
    logic        sign;
    logic [2:0]  nd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];
  exp_t last_exp;
  int   busy_cnt = 0;

  localparam exp_t RESET_EXP = '{digits: 20'h0, sign: 1'b0, nd: 3'd1};

  result_bcd_converter_if #(.IN_W(IN_W), .NDIG(NDIG)) bus ();

  result_bcd_converter #(.IN_W(IN_W), .NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference using plain integer division.
  function automatic exp_t model(input int v, input bit n);
    exp_t e;
    int   t;
    e.digits = '0;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      e.digits[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.nd = 3'd1;
    t = v / 10;
    while (t > 0) begin
      e.nd = e.nd + 3'd1;
      t = t / 10;
    end
    e.sign = n && (v != 0);
    return e;
  endfunction

  // Monitor: pops on DONE, otherwise requires the outputs to hold.
  initial last_exp = RESET_EXP;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      last_exp = RESET_EXP;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        last_exp = sb.pop_front();
        chk("busy_cycles", busy_cnt, IN_W);
      end
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end
    chk("digits", {12'd0, bus.digits}, {12'd0, last_exp.digits});
    chk("sign", {31'd0, bus.sign}, {31'd0, last_exp.sign});
    chk("num_digits", {29'd0, bus.num_digits}, {29'd0, last_exp.nd});
  end

  // mode 0: random noise on inputs while busy; mode 1: directed ignored STARTs.
  task automatic convert(input int v, input bit n, input int mode);
    bus.start  = 1'b1;
    bus.result = 16'(v);
    bus.neg    = n;
    sb.push_back(model(v, n));
    @(posedge clk);
    #1;
    for (int k = 1; k <= IN_W + 1; k++) begin
      bus.start = 1'b0;
      if (mode == 0) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.result = 16'($urandom);
        bus.neg    = 1'($urandom);
      end else if (k == 4) begin
        bus.start  = 1'b1;
        bus.result = 16'd9;
        bus.neg    = ~n;
      end else if (k == IN_W + 1) begin
        bus.start  = 1'b1;
        bus.result = 16'd7;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    bus.start  = 1'b0;
    bus.result = '0;
    bus.neg    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", {12'd0, bus.digits}, 32'd0);
    chk("reset_sign", {31'd0, bus.sign}, 32'd0);
    chk("reset_num_digits", {29'd0, bus.num_digits}, 32'd1);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    convert(65535, 1'b0, 0);
    convert(56, 1'b1, 0);
    convert(0, 1'b1, 0);
    convert(1000, 1'b0, 1);

    // Abort mid-conversion: no DONE, outputs drop to reset values immediately.
    bus.start  = 1'b1;
    bus.result = 16'd1234;
    bus.neg    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_digits", {12'd0, bus.digits}, 32'd0);
    chk("abort_sign", {31'd0, bus.sign}, 32'd0);
    chk("abort_num_digits", {29'd0, bus.num_digits}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    convert(100, 1'b0, 0);
    convert(10000, 1'b1, 0);
    convert(9, 1'b0, 0);
    convert(99999 % 65536, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                      : int'($urandom_range(0, 120));
      convert(v, 1'($urandom), 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the calculator ALU. It captures the ALU's 16-bit unsigned magnitude and negative flag on a start strobe. It converts the magnitude to packed decimal digits with shift-and-add-3 (double dabble), one bit per clock. It then presents digits, sign and significant-digit count to the display driver with a done pulse.

## Interface
- IN_W, 16, width of the binary magnitude input (matches ALU RESULT).
- NDIG, 5, number of BCD digits produced; must satisfy 10^NDIG > 2^IN_W − 1.
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, asynchronous and active-high.
- START  input  1  request conversion; sampled only in IDLE.
- RESULT  input  IN_W  unsigned magnitude from ALU.
- NEG  input  1  ALU negative flag; RESULT is the magnitude when NEG=1.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when outputs are updated.
- DIGITS  output  4*NDIG  packed BCD, digit 0 (units) in bits [3:0].
- SIGN  output  1  display minus sign.
- NUM_DIGITS  output  3  count of significant digits, range 1..NDIG.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- **IDLE:** START=1 captures RESULT into the binary shift register and NEG into a sign register. It clears the BCD accumulator and the bit counter, then moves to SHIFT. START=0 stays in IDLE.
- **SHIFT:** each cycle, every BCD digit ≥5 gets +3, then {BCD, binary} shifts left one bit and the counter increments.
  - After IN_W shifts, register DIGITS, SIGN and NUM_DIGITS, then go to FINISH.
- **FINISH:** DONE=1 for one cycle, then return to IDLE unconditionally.
- START outside IDLE is ignored. This includes during FINISH. There is no queuing.
- RESULT and NEG changes after capture have no effect on the conversion in progress.
- SIGN = captured NEG AND (captured RESULT ≠ 0). Negative zero displays as "0".
- NUM_DIGITS = index of the most significant nonzero digit + 1. It is 1 when the value is 0.
- DIGITS, SIGN and NUM_DIGITS hold their last completed values until the next FINISH. They never show intermediate values.
- BUSY = 1 exactly in SHIFT state.

## Timing
- Reset values:
  - DIGITS=0, SIGN=0, NUM_DIGITS=1, BUSY=0, DONE=0.
  - State=IDLE; internal registers cleared.
- RST asserted at any time, including mid-SHIFT or during FINISH:
  - Asynchronously forces reset values.
  - The aborted conversion produces no DONE.
  - The output registers return to reset values and do not retain the prior result.
- Latency, with START sampled at edge 0:
  - Edges 1..IN_W perform shifts; BUSY is high between edge 0 and edge IN_W.
  - Outputs update at edge IN_W, and DONE is high for the cycle between edges IN_W and IN_W+1.
  - The default is 16 shift cycles; DONE is visible 16 cycles after the START edge.
- Next START is accepted at edge IN_W+2 or later, so throughput is one conversion per IN_W+2 cycles.
- Add-3 correction and shift happen in the same cycle, using combinational correction from the current register contents.

## Structure
- Shared package calc_pkg:
  - state enum (IDLE, SHIFT, FINISH);
  - default IN_W/NDIG constants;
  - BCD digit width constant 4.
- Sub-module bcd_add3: 4-bit in, 4-bit out, out = in ≥ 5 ? in+3 : in. Instantiate NDIG times via generate.
- Top contains the FSM, bit counter (width clog2(IN_W+1)), shift registers, output registers and the leading-digit priority encoder for NUM_DIGITS.

## Test plan
- **Reset:** RST=1 mid-idle → DIGITS=0, SIGN=0, NUM_DIGITS=1, BUSY=0, DONE=0.
- **Maximum value:** RESULT=65535, NEG=0, START one cycle → BUSY 16 cycles, then DONE pulse. Expect DIGITS=20'h65535, NUM_DIGITS=5, SIGN=0.
- **Negative subtraction result:** RESULT=56, NEG=1 → DIGITS=20'h00056, NUM_DIGITS=2, SIGN=1.
- **Negative zero:** RESULT=0, NEG=1 → DIGITS=0, NUM_DIGITS=1, SIGN=0.
- **Ignored inputs while busy:** START with RESULT=1000. Four cycles later, pulse START with RESULT=9 and change NEG → single DONE only, with DIGITS=20'h01000 and NUM_DIGITS=4. A START on the DONE cycle is also ignored.
- **Reset mid-conversion:** START with RESULT=1234, RST at shift cycle 8 → no DONE, outputs at reset values. A fresh START with RESULT=100 then completes normally with DIGITS=20'h00100 and NUM_DIGITS=3.
